// File: rtl/fmps_readout_scheduler_pkg.sv
// Shared definitions for the FMPS readout scheduler: FSM state codes and
// the bit layout of the AXI-Stream TUSER sideband.
package fmps_pkg;

  typedef logic [2:0] fmpsState_t;

  localparam fmpsState_t ST_IDLE    = 3'd0;
  localparam fmpsState_t ST_SC_ADDR = 3'd1;
  localparam fmpsState_t ST_SC_WAIT = 3'd2;
  localparam fmpsState_t ST_SC_EMIT = 3'd3;
  localparam fmpsState_t ST_UB_ADDR = 3'd4;
  localparam fmpsState_t ST_UB_WAIT = 3'd5;

  // TUSER = {aborted, present, index}; index field starts at bit 0.
  localparam int TUSER_INDEX_LSB = 0;

  function automatic int tuserPresentBit(input int indexWidth);
    return indexWidth;
  endfunction

  function automatic int tuserAbortedBit(input int indexWidth);
    return indexWidth + 1;
  endfunction

endpackage

// File: rtl/fmps_readout_scheduler.sv
// FMPS readout scheduler: once per FA cycle walks the readout DPRAM from
// index 0 to lastIndex and streams each entry to the Mitigation Node. The
// same read port serves single-word MicroBlaze diagnostic reads between scans.
module fmps_readout_scheduler
  import fmps_pkg::*;
#(
  parameter int INDEX_WIDTH = 5,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   sysClk,
  input  logic                   sysReset,
  input  logic                   FAstrobe,
  input  logic                   readoutValid,
  input  logic [INDEX_WIDTH-1:0] lastIndex,
  output logic [INDEX_WIDTH-1:0] fmpsReadoutAddress,
  input  logic [31:0]            fmpsReadout,
  input  logic                   fmpsReadoutPresent,
  output logic                   M_TVALID,
  input  logic                   M_TREADY,
  output logic [31:0]            M_TDATA,
  output logic [INDEX_WIDTH+1:0] M_TUSER,
  output logic                   M_TLAST,
  input  logic                   uBreadStrobe,
  input  logic [INDEX_WIDTH-1:0] uBreadAddress,
  output logic [31:0]            uBreadout,
  output logic                   uBreadPresent,
  output logic                   uBreadDone,
  output logic                   scanBusy,
  output logic [COUNT_WIDTH-1:0] scanCount,
  output logic [COUNT_WIDTH-1:0] abortCount
);

  localparam int USER_WIDTH  = INDEX_WIDTH + 2;
  localparam int PRESENT_BIT = tuserPresentBit(INDEX_WIDTH);
  localparam int ABORTED_BIT = tuserAbortedBit(INDEX_WIDTH);

  fmpsState_t stateReg, stateNext;

  logic                   readoutValidD;
  logic                   scanTrigger;
  logic [INDEX_WIDTH-1:0] idxReg, idxInc, lastReg;
  logic [INDEX_WIDTH-1:0] ubAddrReg, addrHoldReg;
  logic                   ubPendingReg;
  logic [31:0]            tdataReg;
  logic [USER_WIDTH-1:0]  tuserReg;
  logic                   tlastReg;
  logic                   busyReg;
  logic [31:0]            ubDataReg;
  logic                   ubPresentReg, ubDoneReg;
  logic [COUNT_WIDTH-1:0] scanCountReg, abortCountReg;
  logic [USER_WIDTH-1:0]  beatUser, termUserCur, termUserInc;

  assign scanTrigger = readoutValid & ~readoutValidD;
  assign idxInc      = idxReg + INDEX_WIDTH'(1);

  // TUSER images: a normal beat, and terminators for the current/next index
  always_comb begin
    beatUser    = '0;
    termUserCur = '0;
    termUserInc = '0;
    beatUser[TUSER_INDEX_LSB +: INDEX_WIDTH]    = idxReg;
    beatUser[PRESENT_BIT]                       = fmpsReadoutPresent;
    termUserCur[TUSER_INDEX_LSB +: INDEX_WIDTH] = idxReg;
    termUserCur[ABORTED_BIT]                    = 1'b1;
    termUserInc[TUSER_INDEX_LSB +: INDEX_WIDTH] = idxInc;
    termUserInc[ABORTED_BIT]                    = 1'b1;
  end

  // State register
  always_ff @(posedge sysClk) begin
    if (sysReset) stateReg <= ST_IDLE;
    else          stateReg <= stateNext;
  end

  // Next-state logic: a scan trigger beats a pending uB read in IDLE
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE: begin
        if (scanTrigger)                        stateNext = ST_SC_ADDR;
        else if (ubPendingReg || uBreadStrobe)  stateNext = ST_UB_ADDR;
      end
      ST_SC_ADDR: stateNext = FAstrobe ? ST_SC_EMIT : ST_SC_WAIT;
      ST_SC_WAIT: stateNext = ST_SC_EMIT;
      ST_SC_EMIT: begin
        if (M_TREADY) begin
          if (tlastReg)      stateNext = ST_IDLE;
          else if (FAstrobe) stateNext = ST_SC_EMIT;  // terminator follows immediately
          else               stateNext = ST_SC_ADDR;
        end
      end
      ST_UB_ADDR: stateNext = ST_UB_WAIT;
      ST_UB_WAIT: stateNext = ST_IDLE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: read address mux and stream valid
  always_comb begin
    fmpsReadoutAddress = addrHoldReg;
    M_TVALID           = 1'b0;
    case (stateReg)
      ST_SC_ADDR: fmpsReadoutAddress = idxReg;
      ST_UB_ADDR: fmpsReadoutAddress = ubAddrReg;
      ST_SC_EMIT: M_TVALID = 1'b1;
      default: ;
    endcase
  end

  // Datapath: beat registers, uB read port, counters, trigger edge detect
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      // Track the input through reset so a level already high is not an edge.
      readoutValidD <= readoutValid;
      idxReg        <= '0;
      lastReg       <= '0;
      ubAddrReg     <= '0;
      addrHoldReg   <= '0;
      ubPendingReg  <= 1'b0;
      tdataReg      <= '0;
      tuserReg      <= '0;
      tlastReg      <= 1'b0;
      busyReg       <= 1'b0;
      ubDataReg     <= '0;
      ubPresentReg  <= 1'b0;
      ubDoneReg     <= 1'b0;
      scanCountReg  <= '0;
      abortCountReg <= '0;
    end else begin
      readoutValidD <= readoutValid;
      addrHoldReg   <= fmpsReadoutAddress;
      ubDoneReg     <= 1'b0;

      // A strobe during UB_ADDR/UB_WAIT re-arms pending for a second read.
      if (uBreadStrobe) begin
        ubPendingReg <= 1'b1;
        ubAddrReg    <= uBreadAddress;
      end else if (stateReg == ST_UB_ADDR) begin
        ubPendingReg <= 1'b0;
      end

      case (stateReg)
        ST_IDLE: begin
          if (scanTrigger) begin
            idxReg  <= '0;
            lastReg <= lastIndex;
            busyReg <= 1'b1;
          end
        end
        ST_SC_ADDR: begin
          if (FAstrobe) begin
            tdataReg <= '0;
            tuserReg <= termUserCur;
            tlastReg <= 1'b1;
          end
        end
        ST_SC_WAIT: begin
          if (FAstrobe) begin
            tdataReg <= '0;
            tuserReg <= termUserCur;
            tlastReg <= 1'b1;
          end else begin
            tdataReg <= fmpsReadoutPresent ? fmpsReadout : 32'd0;
            tuserReg <= beatUser;
            tlastReg <= (idxReg == lastReg);
          end
        end
        ST_SC_EMIT: begin
          if (M_TREADY) begin
            if (tlastReg) begin
              busyReg <= 1'b0;
              if (tuserReg[ABORTED_BIT]) abortCountReg <= abortCountReg + COUNT_WIDTH'(1);
              else                       scanCountReg  <= scanCountReg + COUNT_WIDTH'(1);
            end else begin
              idxReg <= idxInc;
              if (FAstrobe) begin
                tdataReg <= '0;
                tuserReg <= termUserInc;
                tlastReg <= 1'b1;
              end
            end
          end else if (FAstrobe) begin
            tuserReg[ABORTED_BIT] <= 1'b1;
            tlastReg              <= 1'b1;
          end
        end
        ST_UB_WAIT: begin
          ubDataReg    <= fmpsReadout;
          ubPresentReg <= fmpsReadoutPresent;
          ubDoneReg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign M_TDATA       = tdataReg;
  assign M_TUSER       = tuserReg;
  assign M_TLAST       = tlastReg;
  assign uBreadout     = ubDataReg;
  assign uBreadPresent = ubPresentReg;
  assign uBreadDone    = ubDoneReg;
  assign scanBusy      = busyReg;
  assign scanCount     = scanCountReg;
  assign abortCount    = abortCountReg;

endmodule

// File: tb/tb_fmps_readout_scheduler.sv
// Scoreboard bench for fmps_readout_scheduler: expected beats and uB reads
// are queued when stimulus is issued; a negedge monitor pops and compares.
module tb_fmps_readout_scheduler;

  localparam int IW    = 5;
  localparam int CW    = 16;
  localparam int UW    = IW + 2;
  localparam int NODES = 1 << IW;

  logic          sysClk = 1'b0;
  logic          sysReset, FAstrobe, readoutValid;
  logic [IW-1:0] lastIndex, fmpsReadoutAddress;
  logic [31:0]   fmpsReadout;
  logic          fmpsReadoutPresent;
  logic          M_TVALID;
  logic          M_TREADY = 1'b0;
  logic [31:0]   M_TDATA;
  logic [UW-1:0] M_TUSER;
  logic          M_TLAST;
  logic          uBreadStrobe;
  logic [IW-1:0] uBreadAddress;
  logic [31:0]   uBreadout;
  logic          uBreadPresent, uBreadDone, scanBusy;
  logic [CW-1:0] scanCount, abortCount;

  always #5 sysClk = ~sysClk;

  fmps_readout_scheduler #(.INDEX_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .FAstrobe(FAstrobe),
    .readoutValid(readoutValid), .lastIndex(lastIndex),
    .fmpsReadoutAddress(fmpsReadoutAddress), .fmpsReadout(fmpsReadout),
    .fmpsReadoutPresent(fmpsReadoutPresent), .M_TVALID(M_TVALID),
    .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TUSER(M_TUSER),
    .M_TLAST(M_TLAST), .uBreadStrobe(uBreadStrobe),
    .uBreadAddress(uBreadAddress), .uBreadout(uBreadout),
    .uBreadPresent(uBreadPresent), .uBreadDone(uBreadDone),
    .scanBusy(scanBusy), .scanCount(scanCount), .abortCount(abortCount)
  );

  // DPRAM contents (stimulus) and its one-cycle registered read port
  logic [31:0] mem [NODES];
  bit          memPres [NODES];
  always @(posedge sysClk) begin
    fmpsReadout        <= mem[fmpsReadoutAddress];
    fmpsReadoutPresent <= memPres[fmpsReadoutAddress];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: a scan is the list of entries 0..last, absent ones zeroed
  typedef struct packed {logic [31:0] data; logic [UW-1:0] user; logic last;} beat_t;
  typedef struct packed {logic [31:0] data; logic present;} ubRd_t;
  beat_t beatQ[$];
  ubRd_t ubQ[$];
  int expScan = 0;
  int expAbort = 0;

  function automatic logic [UW-1:0] mkUser(input bit aborted, input bit present, input int idx);
    return {aborted, present, IW'(idx)};
  endfunction

  // Push `count` normal beats of a scan ending at `last`, optionally a terminator
  task automatic expectBeats(input int last, input int count, input bit abortTail);
    beat_t b;
    for (int i = 0; i < count; i++) begin
      b.data = memPres[i] ? mem[i] : 32'd0;
      b.user = mkUser(1'b0, memPres[i], i);
      b.last = (i == last);
      beatQ.push_back(b);
    end
    if (abortTail) begin
      b.data = 32'd0;
      b.user = mkUser(1'b1, 1'b0, count);
      b.last = 1'b1;
      beatQ.push_back(b);
    end
  endtask

  // TREADY driver: 0 random, 1 high, 2 stall index 1 for 10 cycles, 3 low
  int readyMode = 1;
  int stallCnt  = 0;
  always @(posedge sysClk) begin
    #1;
    case (readyMode)
      0: M_TREADY = 1'($urandom_range(0, 1));
      1: M_TREADY = 1'b1;
      2: begin
        if (M_TVALID && M_TUSER[IW-1:0] == 5'd1 && stallCnt < 10) begin
          M_TREADY = 1'b0;
          stallCnt++;
        end else begin
          M_TREADY = 1'b1;
        end
      end
      default: M_TREADY = 1'b0;
    endcase
  end

  // Monitor: stall stability, stream beats and uB reads against the queues
  bit            prevStall = 1'b0;
  bit            prevFa = 1'b0;
  logic [31:0]   prevData;
  logic [UW-1:0] prevUser;
  logic          prevLast;
  logic [IW-1:0] prevAddr;
  always @(negedge sysClk) begin
    beat_t eb;
    ubRd_t eu;
    if (sysReset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        check("stall_tvalid", 64'(M_TVALID), 64'(1));
        check("stall_tdata", 64'(M_TDATA), 64'(prevData));
        check("stall_index", 64'(M_TUSER[IW-1:0]), 64'(prevUser[IW-1:0]));
        check("stall_present", 64'(M_TUSER[IW]), 64'(prevUser[IW]));
        check("stall_addr", 64'(fmpsReadoutAddress), 64'(prevAddr));
        if (prevFa) begin
          check("fa_forces_last_aborted", 64'({M_TLAST, M_TUSER[UW-1]}), 64'(2'b11));
        end else begin
          check("stall_tlast", 64'(M_TLAST), 64'(prevLast));
          check("stall_aborted", 64'(M_TUSER[UW-1]), 64'(prevUser[UW-1]));
        end
      end
      if (M_TVALID) check("busy_during_beat", 64'(scanBusy), 64'(1));
      if (M_TVALID && M_TREADY) begin
        if (beatQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: got index %0d data %0h, expected no beat", M_TUSER[IW-1:0], M_TDATA);
        end else begin
          eb = beatQ.pop_front();
          check("beat_tdata", 64'(M_TDATA), 64'(eb.data));
          check("beat_tuser", 64'(M_TUSER), 64'(eb.user));
          check("beat_tlast", 64'(M_TLAST), 64'(eb.last));
          $display("beat idx=%0d data=%08h user=%0h last=%0d", M_TUSER[IW-1:0], M_TDATA, M_TUSER, M_TLAST);
        end
      end
      if (uBreadDone) begin
        if (ubQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL ub_unexpected: got data %0h, expected no read", uBreadout);
        end else begin
          eu = ubQ.pop_front();
          check("ub_data", 64'(uBreadout), 64'(eu.data));
          check("ub_present", 64'(uBreadPresent), 64'(eu.present));
          $display("ub read data=%08h present=%0d", uBreadout, uBreadPresent);
        end
      end
      prevStall = M_TVALID && !M_TREADY;
    end
    prevFa   = FAstrobe;
    prevData = M_TDATA;
    prevUser = M_TUSER;
    prevLast = M_TLAST;
    prevAddr = fmpsReadoutAddress;
  end

  task automatic fillMem();
    for (int i = 0; i < NODES; i++) begin
      mem[i]     = $urandom;
      memPres[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Falling then rising readoutValid; optionally a uB strobe on the rising cycle
  task automatic newEdge(input int last, input int ubAddr);
    @(posedge sysClk); #1 readoutValid = 1'b0;
    @(posedge sysClk); #1 readoutValid = 1'b1;
    lastIndex = IW'(last);
    if (ubAddr >= 0) begin
      uBreadStrobe  = 1'b1;
      uBreadAddress = IW'(ubAddr);
      ubQ.push_back({mem[ubAddr], memPres[ubAddr]});
    end
    @(posedge sysClk); #1 uBreadStrobe = 1'b0;
    lastIndex = IW'($urandom);
  endtask

  task automatic ubStrobe(input int a);
    @(posedge sysClk); #1 uBreadStrobe = 1'b1;
    uBreadAddress = IW'(a);
    ubQ.push_back({mem[a], memPres[a]});
    @(posedge sysClk); #1 uBreadStrobe = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((beatQ.size() != 0 || ubQ.size() != 0 || scanBusy) && n < 3000) begin
      @(negedge sysClk); n++;
    end
    check({name, "_drain_timeout"}, 64'(n >= 3000), 64'(0));
    repeat (2) @(negedge sysClk);
  endtask

  task automatic waitTvalid(input string name);
    int n = 0;
    while (!M_TVALID && n < 200) begin
      @(negedge sysClk); n++;
    end
    check({name, "_tvalid_timeout"}, 64'(n >= 200), 64'(0));
  endtask

  task automatic checkCounts(input string name);
    check({name, "_scanCount"}, 64'(scanCount), 64'(expScan % (1 << CW)));
    check({name, "_abortCount"}, 64'(abortCount), 64'(expAbort % (1 << CW)));
  endtask

  initial begin
    int n;
    int last;
    sysReset = 1'b1; FAstrobe = 1'b0; readoutValid = 1'b0; lastIndex = '0;
    uBreadStrobe = 1'b0; uBreadAddress = '0;
    for (int i = 0; i < NODES; i++) begin mem[i] = 32'd0; memPres[i] = 1'b0; end
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    check("rst_tvalid", 64'(M_TVALID), 64'(0));
    check("rst_tdata", 64'(M_TDATA), 64'(0));
    check("rst_tuser", 64'(M_TUSER), 64'(0));
    check("rst_tlast", 64'(M_TLAST), 64'(0));
    check("rst_addr", 64'(fmpsReadoutAddress), 64'(0));
    check("rst_ubdone", 64'(uBreadDone), 64'(0));
    check("rst_ubdata", 64'({uBreadout, uBreadPresent}), 64'(0));
    check("rst_busy", 64'(scanBusy), 64'(0));
    checkCounts("rst");
    @(posedge sysClk); #1 sysReset = 1'b0;

    // Directed scan: entries 0 and 2 present
    mem[0] = 32'hA0; memPres[0] = 1'b1;
    mem[1] = 32'h11; memPres[1] = 1'b0;
    mem[2] = 32'hA2; memPres[2] = 1'b1;
    mem[3] = 32'h33; memPres[3] = 1'b0;
    readyMode = 1;
    expectBeats(3, 4, 1'b0); expScan++;
    newEdge(3, -1);
    waitDrain("basic");
    checkCounts("basic");

    // Backpressure on beat 1
    readyMode = 2; stallCnt = 0;
    expectBeats(3, 4, 1'b0); expScan++;
    newEdge(3, -1);
    waitDrain("stall");
    check("stall_length", 64'(stallCnt), 64'(10));
    checkCounts("stall");
    readyMode = 1;

    // FAstrobe while waiting for read data of index 5
    fillMem();
    expectBeats(31, 5, 1'b1); expAbort++;
    newEdge(31, -1);
    n = 0;
    while (!(fmpsReadoutAddress == 5'd5 && !M_TVALID && scanBusy) && n < 300) begin
      @(negedge sysClk); n++;
    end
    check("abort_find_timeout", 64'(n >= 300), 64'(0));
    @(posedge sysClk); #1 FAstrobe = 1'b1;
    @(posedge sysClk); #1 FAstrobe = 1'b0;
    waitDrain("abort_wait");
    checkCounts("abort_wait");
    expectBeats(2, 3, 1'b0); expScan++;
    newEdge(2, -1);
    waitDrain("after_abort");
    checkCounts("after_abort");

    // FAstrobe while beat 0 is stalled: same beat, now last and aborted
    readyMode = 3;
    begin
      beat_t b;
      b.data = memPres[0] ? mem[0] : 32'd0;
      b.user = mkUser(1'b1, memPres[0], 0);
      b.last = 1'b1;
      beatQ.push_back(b);
    end
    expAbort++;
    newEdge(4, -1);
    waitTvalid("abort_emit");
    @(posedge sysClk); #1 FAstrobe = 1'b1;
    @(posedge sysClk); #1 FAstrobe = 1'b0;
    readyMode = 1;
    waitDrain("abort_emit");
    checkCounts("abort_emit");

    // uB strobe in the same cycle as the scan trigger: scan goes first
    expectBeats(1, 2, 1'b0); expScan++;
    newEdge(1, 7);
    n = 0;
    while (!uBreadDone && n < 100) begin @(negedge sysClk); n++; end
    check("tie_ub_timeout", 64'(n >= 100), 64'(0));
    check("tie_scan_done_first", 64'(scanCount), 64'(expScan));
    check("tie_busy_clear", 64'(scanBusy), 64'(0));
    waitDrain("tie");

    // uB latency from IDLE, and a strobe landing in UB_WAIT gives a second read
    ubStrobe(9);
    @(posedge sysClk); #1 uBreadStrobe = 1'b1;
    uBreadAddress = IW'(20);
    ubQ.push_back({mem[20], memPres[20]});
    @(posedge sysClk); #1 uBreadStrobe = 1'b0;
    @(negedge sysClk);
    check("ub_latency", 64'(uBreadDone), 64'(1));
    waitDrain("ub_double");

    // Reset while a beat is stalled in SC_EMIT; held-high readoutValid must not retrigger
    readyMode = 3;
    newEdge(3, -1);
    waitTvalid("reset_emit");
    @(posedge sysClk); #1 sysReset = 1'b1;
    @(posedge sysClk); #1 sysReset = 1'b0;
    @(negedge sysClk);
    expScan = 0; expAbort = 0;
    check("reset_emit_tvalid", 64'(M_TVALID), 64'(0));
    check("reset_emit_busy", 64'(scanBusy), 64'(0));
    checkCounts("reset_emit");
    readyMode = 1;
    repeat (30) @(negedge sysClk);
    check("reset_level_no_scan", 64'({scanBusy, M_TVALID}), 64'(0));
    expectBeats(2, 3, 1'b0); expScan++;
    newEdge(2, -1);
    waitDrain("post_reset");
    checkCounts("post_reset");

    // Level held through three FA periods: no further scans, idle FAstrobe harmless
    for (int p = 0; p < 3; p++) begin
      repeat (20) @(posedge sysClk);
      #1 FAstrobe = 1'b1;
      @(posedge sysClk); #1 FAstrobe = 1'b0;
    end
    repeat (5) @(negedge sysClk);
    check("held_high_busy", 64'(scanBusy), 64'(0));
    checkCounts("held_high");

    // Random scans with random backpressure and occasional uB reads
    for (int it = 0; it < 10; it++) begin
      last = (it == 0) ? 0 : (it == 1) ? NODES - 1 : int'($urandom_range(0, NODES - 1));
      fillMem();
      readyMode = 0;
      expectBeats(last, last + 1, 1'b0); expScan++;
      newEdge(last, -1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 20)) @(posedge sysClk);
        ubStrobe(int'($urandom_range(0, NODES - 1)));
      end
      waitDrain("random");
      checkCounts("random");
    end

    check("beat_queue_empty", 64'(beatQ.size()), 64'(0));
    check("ub_queue_empty", 64'(ubQ.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
